// File: rtl/divu_p6y3.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/rdy/done handshake.
// Optional divide-by-zero fast path and dz flag enabled by defining DIVU_DIV0_FLAG_EN.
module divu_p6y3 #(
  parameter int P_WIDTH = 6,
  parameter int Y_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [P_WIDTH-1:0] p,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] q,
  output logic [Y_WIDTH-1:0] r,
  output logic               rdy,
  output logic               done
`ifdef DIVU_DIV0_FLAG_EN
  ,
  output logic               dz
`endif
);

  localparam int CW = $clog2(P_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [P_WIDTH-1:0] dq_q, dq_d;
  logic [Y_WIDTH-1:0] v_q, v_d;
  logic [Y_WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [P_WIDTH-1:0] quo_q, quo_d;
  logic [Y_WIDTH-1:0] rmd_q, rmd_d;
`ifdef DIVU_DIV0_FLAG_EN
  logic               dz_q, dz_d;
`endif

  logic [Y_WIDTH:0]   trial;
  logic               fits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      v_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef DIVU_DIV0_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      v_q     <= v_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
`ifdef DIVU_DIV0_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // The partial remainder only needs Y_WIDTH bits stored: the subtraction is done modulo
  // 2^Y_WIDTH, while the compare still sees the full Y_WIDTH+1-bit trial value.
  // The dividend register doubles as the quotient shift register.
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    v_d     = v_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
`ifdef DIVU_DIV0_FLAG_EN
    dz_d    = dz_q;
`endif
    trial   = {rem_q, dq_q[P_WIDTH-1]};
    fits    = (trial >= {1'b0, v_q});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dq_d    = p;
          v_d     = y;
          rem_d   = '0;
          cnt_d   = CW'(P_WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
`ifdef DIVU_DIV0_FLAG_EN
        if (v_q == '0) begin
          quo_d   = '1;
          rmd_d   = dq_q[Y_WIDTH-1:0];
          dz_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else
`endif
        begin
          rem_d = fits ? (trial[Y_WIDTH-1:0] - v_q) : trial[Y_WIDTH-1:0];
          dq_d  = {dq_q[P_WIDTH-2:0], fits};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quo_d   = {dq_q[P_WIDTH-2:0], fits};
            rmd_d   = rem_d;
`ifdef DIVU_DIV0_FLAG_EN
            dz_d    = 1'b0;
`endif
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign q    = quo_q;
  assign r    = rmd_q;
  assign rdy  = (state_q == S_IDLE);
  assign done = (state_q == S_DONE);
`ifdef DIVU_DIV0_FLAG_EN
  assign dz   = dz_q;
`endif

endmodule

// File: tb/tb_divu_p6y3.sv
// Scoreboard bench for divu_p6y3: the driver pushes expected results computed with plain
// division, a negedge monitor pops and compares whenever done is high.
module tb_divu_p6y3;

  localparam int PW = 6;
  localparam int YW = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] p     = '0;
  logic [YW-1:0] y     = '0;
  logic [PW-1:0] q;
  logic [YW-1:0] r;
  logic          rdy;
  logic          done;
`ifdef DIVU_DIV0_FLAG_EN
  logic          dz;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int q;
    int r;
    int dz;
    int doneCycle;
  } exp_t;

  exp_t sb[$];
  exp_t expItem;

  divu_p6y3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .p     (p),
    .y     (y),
    .q     (q),
    .r     (r),
    .rdy   (rdy),
    .done  (done)
`ifdef DIVU_DIV0_FLAG_EN
    ,
    .dz    (dz)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division; y==0 yields all-ones quotient and the low dividend bits.
  function automatic exp_t model(input int pv, input int yv, input int accept);
    exp_t e;
    if (yv == 0) begin
      e.q  = (1 << PW) - 1;
      e.r  = pv % (1 << YW);
      e.dz = 1;
`ifdef DIVU_DIV0_FLAG_EN
      e.doneCycle = accept + 1;
`else
      e.doneCycle = accept + PW;
`endif
    end else begin
      e.q  = pv / yv;
      e.r  = pv % yv;
      e.dz = 0;
      e.doneCycle = accept + PW;
    end
    return e;
  endfunction

  task automatic waitReady();
    int waitCnt = 0;
    @(negedge clk);
    while (!rdy && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rdy) checkOutput("rdyTimeout", 0, 1);
  endtask

  // Issue one division; afterwards p/y are scrambled to show they were latched.
  task automatic applyStimulus(input int pv, input int yv, input bit track);
    waitReady();
    if (!rdy) return;
    start = 1'b1;
    p     = PW'(pv);
    y     = YW'(yv);
    if (track) sb.push_back(model(pv, yv, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    p     = PW'($urandom);
    y     = YW'($urandom);
    checkOutput("rdyLowAfterAccept", int'(rdy), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("spuriousDone", 1, 0);
      end else begin
        expItem = sb.pop_front();
        checkOutput("quotient", int'(q), expItem.q);
        checkOutput("remainder", int'(r), expItem.r);
        checkOutput("doneCycle", cyc, expItem.doneCycle);
`ifdef DIVU_DIV0_FLAG_EN
        checkOutput("dzFlag", int'(dz), expItem.dz);
`endif
      end
    end
  end

  initial begin
    int drain;
    int pv;
    int yv;

    #12;
    checkOutput("resetQ", int'(q), 0);
    checkOutput("resetR", int'(r), 0);
    checkOutput("resetRdy", int'(rdy), 1);
    checkOutput("resetDone", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(42, 6, 1);
    applyStimulus(50, 3, 1);
    applyStimulus(5, 7, 1);
    applyStimulus(63, 1, 1);
    applyStimulus(45, 0, 1);

    // Abandon a division with reset in its third RUN cycle; no done may follow.
    applyStimulus(55, 6, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetQ", int'(q), 0);
    checkOutput("midResetR", int'(r), 0);
    checkOutput("midResetRdy", int'(rdy), 1);
    checkOutput("midResetDone", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    applyStimulus(21, 5, 1);

    // A start pulse during RUN must be ignored; rdy stays low through DONE.
    applyStimulus(20, 4, 1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    p     = 6'd9;
    y     = 3'd2;
    checkOutput("rdyLowMidRun", int'(rdy), 0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("doneCycleRdy", int'(rdy), 0);
    checkOutput("doneHigh", int'(done), 1);
    @(negedge clk);
    checkOutput("rdyAfterDone", int'(rdy), 1);

    // Start held high re-triggers on the first IDLE edge.
    waitReady();
    start = 1'b1;
    p     = 6'd59;
    y     = 3'd5;
    sb.push_back(model(59, 5, cyc + 1));
    sb.push_back(model(59, 5, cyc + 1 + PW + 2));
    repeat (9) @(negedge clk);
    start = 1'b0;

    for (int pi = 0; pi < (1 << PW); pi++) begin
      for (int yi = 1; yi < (1 << YW); yi++) begin
        applyStimulus(pi, yi, 1);
      end
    end

    for (int xi = 0; xi < (1 << YW); xi++) begin
      for (int yi = 1; yi < (1 << YW); yi++) begin
        applyStimulus(xi * yi, yi, 1);
      end
    end

    for (int n = 0; n < 200; n++) begin
      pv = int'($urandom_range(0, (1 << PW) - 1));
      yv = int'($urandom_range(0, (1 << YW) - 1));
      applyStimulus(pv, yv, 1);
    end

    drain = 0;
    while (sb.size() != 0 && drain < 40) begin
      @(negedge clk);
      drain++;
    end
    checkOutput("scoreboardDrained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
